// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared loader states and stream framing constants
package program_loader_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_WORD,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - big-endian 8-to-32 shift register with byte index
module word_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        full
);

    logic [1:0] byte_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (shift) begin
            word     <= {word[23:0], byte_in};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // High when the next shift completes the word.
    assign full = (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot image loader; PROGLOAD_CHECKSUM_EN adds an XOR trailer check
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

    state_t              state, state_next;
    logic [15:0]         len;
    logic [ADDR_W-1:0]   word_cnt;
    logic [16:0]         cnt_plus;
    logic [15:0]         len_hdr;
    logic                xfer, clear, asm_shift, asm_full;
    logic [31:0]         asm_word;

`ifdef PROGLOAD_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHECK;
    logic [7:0] csum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         csum <= '0;
        else if (clear)     csum <= '0;
        else if (asm_shift) csum <= csum ^ byte_data;
    end
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    word_assembler u_asm (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .shift   (asm_shift),
        .byte_in (byte_data),
        .word    (asm_word),
        .full    (asm_full)
    );

    assign xfer     = byte_valid && byte_ready;
    assign len_hdr  = {len[15:8], byte_data};
    // Widened so a full-capacity image completes before the counter wraps.
    assign cnt_plus = {{(17 - ADDR_W){1'b0}}, word_cnt} + 17'd1;

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        asm_shift  = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_next = S_LEN_HI;
                    clear      = 1'b1;
                end
            end
            S_LEN_HI: if (xfer) state_next = S_LEN_LO;
            S_LEN_LO: begin
                if (xfer) begin
                    if ({1'b0, len_hdr} > CAPACITY) state_next = S_ERR;
                    else if (len_hdr == 16'd0)      state_next = S_TAIL;
                    else                            state_next = S_WORD;
                end
            end
            S_WORD: begin
                if (xfer) begin
                    asm_shift = 1'b1;
                    if (asm_full) state_next = S_WRITE;
                end
            end
            S_WRITE: state_next = (cnt_plus == {1'b0, len}) ? S_TAIL : S_WORD;
`ifdef PROGLOAD_CHECKSUM_EN
            S_CHECK: if (xfer) state_next = (byte_data == csum) ? S_DONE : S_ERR;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_next;
            byte_ready <= state_next inside {S_LEN_HI, S_LEN_LO, S_WORD, S_CHECK};
            mem_we     <= (state_next == S_WRITE);
            cpu_hold   <= (state_next != S_DONE);
            busy       <= !(state_next inside {S_IDLE, S_DONE, S_ERR});
            done       <= (state_next == S_DONE);
            error      <= (state_next == S_ERR);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len      <= '0;
            word_cnt <= '0;
        end else begin
            if (clear)                         word_cnt <= '0;
            else if (state == S_WRITE)         word_cnt <= word_cnt + ADDR_W'(1);
            if (state == S_LEN_HI && xfer)     len[15:8] <= byte_data;
            else if (state == S_LEN_LO && xfer) len[7:0] <= byte_data;
        end
    end

    assign mem_addr  = word_cnt;
    assign mem_wdata = asm_word;

endmodule
